// File: rtl/serial_mag_comp_if.sv
// Handshake and operand bundle for the digit-serial magnitude comparator.
// The controller uses the master side and the comparator uses the slave side.
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       i;
  logic             busy;
  logic             done;
  logic [2:0]       y;

  modport master (output start, output a, output b, output i,
                  input  busy,  input  done, input  y);
  modport slave  (input  start, input  a, input  b, input  i,
                  output busy,  output done, output y);
endinterface

// File: rtl/serial_mag_comp.sv
// Digit-serial 74HC85-style magnitude comparator: one 4-bit digit per clock, MSB digit first.
// Build option SERIAL_MAG_COMP_EARLY_EXIT_EN stops at the first unequal digit; otherwise latency is fixed at DIGITS.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_mag_comp_if.slave   bus
);
  localparam int DIGITS = WIDTH / 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       i_q, i_d;
  logic [3:0]       dig_a, dig_b;
  logic             dig_gt, dig_lt;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
  // {gt,lt} of the MSB-most unequal digit; 00 means all digits so far were equal.
  logic [1:0]       sticky_q, sticky_d, sticky_nx;
`endif

  // All-digits-equal outcome taken from the cascade input {gt,eq,lt}.
  function automatic logic [2:0] cascade_resolve(input logic [2:0] cin);
    logic [2:0] r;
    if (cin[1]) begin
      r = 3'b010;
    end else begin
      case ({cin[2], cin[0]})
        2'b10:   r = 3'b100;
        2'b01:   r = 3'b001;
        2'b11:   r = 3'b000;
        default: r = 3'b101;
      endcase
    end
    return r;
  endfunction

`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
  function automatic logic [2:0] sticky_to_y(input logic [1:0] s);
    return {s[1], 1'b0, s[0]};
  endfunction
`endif

  always_comb begin
    dig_a   = a_q[{idx_q, 2'b00} +: 4];
    dig_b   = b_q[{idx_q, 2'b00} +: 4];
    dig_gt  = (dig_a > dig_b);
    dig_lt  = (dig_a < dig_b);
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
    sticky_d  = sticky_q;
    sticky_nx = sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          i_d     = bus.i;
          idx_d   = IDX_LAST;
          busy_d  = 1'b1;
          state_d = CMP;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
          sticky_d = 2'b00;
`endif
        end
      end
      CMP: begin
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
        if (dig_gt || dig_lt || (idx_q == '0)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = IDX_LAST;
          if (dig_gt)      y_d = 3'b100;
          else if (dig_lt) y_d = 3'b001;
          else             y_d = cascade_resolve(i_q);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        if (sticky_q == 2'b00) sticky_nx = {dig_gt, dig_lt};
        if (idx_q == '0) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          idx_d    = IDX_LAST;
          sticky_d = 2'b00;
          y_d      = (sticky_nx != 2'b00) ? sticky_to_y(sticky_nx) : cascade_resolve(i_q);
        end else begin
          idx_d    = idx_q - IDX_W'(1);
          sticky_d = sticky_nx;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any comparison in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= 3'b000;
      idx_q    <= IDX_LAST;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
      sticky_q <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  // Operand capture; only loaded on acceptance so no reset is needed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    i_q <= i_d;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
Sequential, digit-serial magnitude comparator: the iterative counterpart of the cascaded ic74hc85 chain. Compares two WIDTH-bit operands one 4-bit digit per clock, MSB digit first, stopping at the first unequal digit. When all digits are equal, the result is resolved from a 74HC85-style cascade input. Used where a wide combinational cascade is too slow or too large; start/busy/done handshake to the controlling logic.

Parameters:
WIDTH, 8, operand width in bits; multiple of 4, minimum 4
DIGITS, WIDTH/4, derived digit count; not overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
i  input  3  cascade-in {gt,eq,lt}; captured with a/b
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse; y is valid from this cycle on
y  output  3  result {a>b, a==b, a<b}; held until the next done

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, y=3'b000, digit index=DIGITS-1.
- Reset mid-operation: abandon the comparison; reset values hold on the next edge; no done is produced.
- States: IDLE, CMP.
- IDLE, start=1 at edge E0: latch a, b, i into internal registers; index=DIGITS-1; busy=1; go to CMP. start=0: stay in IDLE.
- CMP, each edge compares latched digits a[4*idx+3:4*idx] vs b[...], unsigned:
  - Digit greater: y=100, done=1, busy=0, go to IDLE.
  - Digit less: y=001, done=1, busy=0, go to IDLE.
  - Digits equal and idx>0: idx decrements; stay in CMP.
  - Digits equal and idx==0: resolve from latched i:
    - eq=1 gives y=010, regardless of gt and lt.
    - {gt,eq,lt}=100 gives 100.
    - 001 gives 001.
    - 101 gives 000.
    - 000 gives 101.
    - Then done=1, busy=0, go to IDLE.
- done is high for exactly one cycle and clears on the next edge unless a new completion occurs.
- Latency: done is high in the cycle after edge E_k, where k is the number of digits examined. 1 ≤ k ≤ DIGITS.
- start is ignored while busy=1. Changes on a, b, i after E0 have no effect.
- Back-to-back: start in the same cycle that done=1 is accepted, because state is already IDLE.
- y changes only on a done edge or on reset.

Optional Feature:
SERIAL_MAG_COMP_EARLY_EXIT_EN
- Defined: early exit as above; latency varies with the data, 1..DIGITS.
- Undefined: always examine all DIGITS digits; latency is fixed at DIGITS.
  - The first unequal digit (MSB-most) is recorded in an internal 2-bit sticky result.
  - Later digits do not override the sticky result.
  - At idx==0, y is the sticky result if one is set, otherwise the cascade resolution.
  - busy and done timing is identical for all data.

Test Plan (WIDTH=8):
- a=8'h5A, b=8'h3C, i=010, start pulse -> y=100, done 1 cycle after E0 (EARLY_EXIT defined); 2 cycles after E0 if undefined.
- a=8'h47, b=8'h49, i=010 -> y=001, done 2 cycles after E0; busy high for exactly 2 cycles.
- a=b=8'h66, cycling i through 010, 100, 001, 101, 000 -> y = 010, 100, 001, 000, 101; done 2 cycles after each start.
- Start accepted with a=8'h10, b=8'h20; change a to 8'hFF and pulse start during busy -> y=001, single done, second start ignored.
- Start a=8'h55, b=8'h55; assert rst on the cycle after E0 -> busy=0, done=0, y=000 after the next edge; no done pulse follows.
- Back-to-back: start held high across a done cycle with a=8'h80, b=8'h7F -> second result y=100, done pulses in consecutive transactions without an idle gap.
